// File: rtl/fifo_lane.sv
// -----------------------------------------------------------------------------
// fifo_lane
// Per-lane byte buffer placed directly upstream of a phy transmit lane. It
// absorbs bursty writes from the packet source, releases one byte per accepted
// pop (registered, one-cycle latency) and exports occupancy watermarks so an
// upstream arbiter can throttle. One instance per lane.
//
// Ports:
//   clk_f        in   sole clock, rising edge
//   reset_L      in   asynchronous active-low reset
//   data_in      in   byte to enqueue
//   push         in   enqueue request
//   pop          in   dequeue request
//   data_out     out  registered dequeued byte (holds when no pop)
//   valid_out    out  data_out carries a freshly dequeued byte this cycle
//   full         out  count == depth
//   empty        out  count == 0
//   almost_full  out  count >= AF_THRESH
//   almost_empty out  count <= AE_THRESH
//   error        out  sticky overflow/underflow flag, cleared only by reset
//   count        out  current occupancy, 0..depth
// -----------------------------------------------------------------------------
module fifo_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk_f,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic push_acc;
    logic pop_acc;
    logic req_rejected;

    // Acceptance is decided from the registered count only. A pop on a full
    // FIFO frees a slot in the same edge, so a simultaneous push is accepted;
    // a push on an empty FIFO never bypasses to the output, so the pop is
    // rejected.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        pop_acc      = 1'b0;
        push_acc     = 1'b0;
        req_rejected = 1'b0;
        pop_acc      = pop && (count != '0);
        push_acc     = push && ((count < DEPTH_C) || pop_acc);
        req_rejected = (push && !push_acc) || (pop && !pop_acc);
    end

    // Storage array: written only on accepted pushes, never reset. Its
    // contents are unobservable until written, so a reset would only cost
    // flops and routing.
    // NOTE: the memory sits in its own reset-less process; putting it under
    // the async reset would force a reset network onto every storage bit.
    always_ff @(posedge clk_f) begin
        if (push_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, output register and sticky error.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;   // wraps modulo depth naturally
            end

            if (pop_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            valid_out <= pop_acc;

            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (req_rejected) begin
                error <= 1'b1;
            end
        end
    end

    // Watermarks depend on the registered count only, so they change just
    // after a clock edge and never follow the current-cycle push/pop.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

endmodule

// File: tb/tb_fifo_lane.sv
// -----------------------------------------------------------------------------
// tb_fifo_lane
// Self-checking bench for fifo_lane. The driver issues push/pop/data each cycle
// and advances a queue-based reference model; bytes the model dequeues are
// pushed into a scoreboard queue. An independent monitor samples the DUT 1
// time unit after each rising edge, pops the scoreboard whenever valid_out is
// high, and compares occupancy, watermarks and the error flag to the model.
// -----------------------------------------------------------------------------
module tb_fifo_lane;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk_f;
    logic          reset_L;
    logic [DW-1:0] data_in;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          error;
    logic [AW:0]   count;

    fifo_lane #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk_f       (clk_f),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .push        (push),
        .pop         (pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .error       (error),
        .count       (count)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    // Reference model state
    logic [DW-1:0] model_q[$];    // bytes currently stored
    logic [DW-1:0] sb_q[$];       // bytes expected on data_out, in order
    bit            model_err;
    bit            exp_valid;
    logic [DW-1:0] last_data;     // value data_out must hold when not valid

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one accepted clock edge.
    task automatic model_step(input bit p, input bit o, input logic [DW-1:0] d);
        bit pop_ok;
        bit push_ok;
        pop_ok  = o && (model_q.size() > 0);
        push_ok = p && ((model_q.size() < DEPTH) || pop_ok);
        if ((p && !push_ok) || (o && !pop_ok)) model_err = 1'b1;
        if (pop_ok) sb_q.push_back(model_q.pop_front());
        exp_valid = pop_ok;
        if (push_ok) model_q.push_back(d);
    endtask

    task automatic model_reset();
        model_q.delete();
        sb_q.delete();
        model_err = 1'b0;
        exp_valid = 1'b0;
        last_data = '0;
    endtask

    // One clock cycle of stimulus: drive at the falling edge, update the model
    // at the rising edge.
    task automatic step(input bit p, input bit o, input logic [DW-1:0] d);
        @(negedge clk_f);
        push    = p;
        pop     = o;
        data_in = d;
        @(posedge clk_f);
        model_step(p, o, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    // Reset asserted between edges: outputs must clear immediately.
    task automatic async_reset();
        @(negedge clk_f);
        push = 1'b0;
        pop  = 1'b0;
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        check("rst_count",     32'(count),     32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_aempty",    32'(almost_empty), 32'd1);
        check("rst_full",      32'(full),      32'd0);
        check("rst_afull",     32'(almost_full), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_data_out",  32'(data_out),  32'd0);
        check("rst_error",     32'(error),     32'd0);
        @(negedge clk_f);
        reset_L = 1'b1;
    endtask

    // Monitor: compares DUT outputs to the model every cycle.
    always @(posedge clk_f) begin
        #1;
        check("valid_out", 32'(valid_out), 32'(exp_valid));
        if (valid_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underrun: valid_out=1 with no expected byte at time %0t", $time);
            end else begin
                last_data = sb_q.pop_front();
                check("data_out", 32'(data_out), 32'(last_data));
            end
        end else begin
            check("data_hold", 32'(data_out), 32'(last_data));
        end
        check("count",        32'(count),        32'(model_q.size()));
        check("full",         32'(full),         32'(model_q.size() == DEPTH));
        check("empty",        32'(empty),        32'(model_q.size() == 0));
        check("almost_full",  32'(almost_full),  32'(model_q.size() >= AF));
        check("almost_empty", 32'(almost_empty), 32'(model_q.size() <= AE));
        check("error",        32'(error),        32'(model_err));
    end

    // Global time limit so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int push_pct;
        int pop_pct;

        reset_L = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        model_reset();
        #3;
        check("init_count", 32'(count),     32'd0);
        check("init_empty", 32'(empty),     32'd1);
        check("init_valid", 32'(valid_out), 32'd0);
        check("init_error", 32'(error),     32'd0);
        @(negedge clk_f);
        reset_L = 1'b1;

        // 1-2: four pushes then four pops
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hA1 + 8'(i));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
        idle(2);

        // 3: fill to full, overflow, drain
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
        step(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        idle(2);

        // 4: clean restart, fill, then push+pop while full (pointer wrap)
        async_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h20 + 8'(i));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h55);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
        idle(2);

        // 5: push+pop on empty, then pop alone
        step(1'b1, 1'b1, 8'h3C);
        step(1'b0, 1'b1, '0);
        idle(2);

        // 6: five bytes stored, reset mid-burst, then pop on empty
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
        async_reset();
        step(1'b0, 1'b1, '0);
        idle(2);

        // Randomized traffic with varying push/pop bias
        async_reset();
        for (int blk = 0; blk < 6; blk++) begin
            case (blk)
                0: begin push_pct = 80; pop_pct = 20; end
                1: begin push_pct = 20; pop_pct = 80; end
                2: begin push_pct = 50; pop_pct = 50; end
                3: begin push_pct = 95; pop_pct = 60; end
                4: begin push_pct = 10; pop_pct = 95; end
                default: begin push_pct = 70; pop_pct = 70; end
            endcase
            for (int i = 0; i < 300; i++) begin
                step($urandom_range(99) < push_pct, $urandom_range(99) < pop_pct,
                     DW'($urandom));
            end
        end
        idle(3);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
